// File: rtl/led_bank_arbiter.sv
// Round-robin arbiter sharing one LED bank between three pattern requesters.
// Each grant holds a captured pattern for a frozen cycle count, then leaves one dark cycle.
module led_bank_arbiter #(
  parameter int LED_W  = 3,
  parameter int HOLD_W = 16
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic [2:0]           req,
  input  logic [3*LED_W-1:0]   pattern,
  input  logic [HOLD_W-1:0]    hold_cycles,
  output logic [2:0]           gnt,
  output logic [2:0]           done,
  output logic [LED_W-1:0]     led,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [HOLD_W-1:0]   cnt_q, cnt_d;
  logic [1:0]          last_q, last_d;
  logic [2:0]          gnt_q, gnt_d;
  logic [2:0]          done_q, done_d;
  logic [LED_W-1:0]    led_q, led_d;
  logic                busy_q, busy_d;

  logic [1:0]          pick;
  logic                pick_vld;
  logic                owner_req;
  int                  idx;

  // Scan downwards so the candidate closest after last_q is assigned last and wins.
  always_comb begin
    pick     = 2'd0;
    pick_vld = 1'b0;
    idx      = 0;
    for (int k = 3; k >= 1; k--) begin
      idx = (int'(last_q) + k) % 3;
      if (req[idx]) begin
        pick     = idx[1:0];
        pick_vld = 1'b1;
      end
    end
  end

  // The current owner is identified by the registered one-hot grant itself.
  assign owner_req = |(req & gnt_q);

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    led_d   = led_q;
    done_d  = '0;

    case (state_q)
      IDLE, GAP: begin
        gnt_d   = '0;
        led_d   = '0;
        state_d = IDLE;
        if (pick_vld) begin
          state_d = HOLD;
          gnt_d   = 3'b001 << pick;
          led_d   = pattern[LED_W*pick +: LED_W];
          cnt_d   = (hold_cycles == '0) ? '0 : hold_cycles - HOLD_W'(1);
          last_d  = pick;
        end
      end
      HOLD: begin
        if (!owner_req) begin
          state_d = GAP;
          gnt_d   = '0;
          led_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = GAP;
          gnt_d   = '0;
          led_d   = '0;
          done_d  = gnt_q;
        end else begin
          cnt_d = cnt_q - HOLD_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        led_d   = '0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    // NOTE: asynchronous reset clears everything at once; last_q=2 gives requester 0 first turn.
    if (!sys_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= 2'd2;
      gnt_q   <= '0;
      done_q  <= '0;
      led_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
    end
  end

  assign gnt  = gnt_q;
  assign done = done_q;
  assign led  = led_q;
  assign busy = busy_q;

endmodule
